// File: rtl/key_match.sv
// rtl/key_match.sv - byte-stream matcher against a snapshot of up to four 8-bit keys
// Optional per-key hit histogram enabled by defining KEY_MATCH_HIST_EN; otherwise hist is tied to zero.
module key_match #(
  parameter int CNT_W = 16
) (
  input  logic             dclk,
  input  logic             reset,
  input  logic [31:0]      keys,
  input  logic [2:0]       num_keys,
  input  logic             arm,
  input  logic [7:0]       din,
  input  logic             dvalid,
  input  logic             eos,
  output logic             match,
  output logic [1:0]       match_idx,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state,
  output logic [31:0]      hist
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t           r_state;
  logic [31:0]      r_snap_keys;
  logic [2:0]       r_snap_cnt;
  logic             r_match;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_count;

  logic             w_hit;
  logic [1:0]       w_idx;
  logic [2:0]       w_arm_cnt;
  logic             w_accept_arm;
  logic             w_consume;
  logic             w_cnt_sat;

  assign w_arm_cnt    = (num_keys > 3'd4) ? 3'd4 : num_keys;
  assign w_accept_arm = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && arm;
  assign w_consume    = (r_state == ST_SCAN) && dvalid;
  assign w_cnt_sat    = &r_count;

  // Priority compare of din against the snapshot keys; scanning downward leaves the lowest hit index.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) < r_snap_cnt) && (r_snap_keys[8*i +: 8] == din)) begin
        w_hit = 1'b1;
        w_idx = 2'(i);
      end
    end
  end

  // Scan FSM: snapshot on arm, one-cycle match pulse per consumed matching byte, saturating total.
  always_ff @(posedge dclk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_snap_keys <= 32'd0;
      r_snap_cnt  <= 3'd0;
      r_match     <= 1'b0;
      r_idx       <= 2'd0;
      r_count     <= '0;
    end else begin
      r_match <= 1'b0;
      r_idx   <= 2'd0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept_arm) begin
            r_snap_keys <= keys;
            r_snap_cnt  <= w_arm_cnt;
            r_count     <= '0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_consume) begin
            r_match <= w_hit;
            r_idx   <= w_hit ? w_idx : 2'd0;
            if (w_hit && !w_cnt_sat) begin
              r_count <= r_count + CNT_W'(1);
            end
            if (eos) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign match       = r_match;
  assign match_idx   = r_idx;
  assign match_count = r_count;
  assign state       = r_state;

`ifdef KEY_MATCH_HIST_EN
  logic [7:0] r_hist [4];

  // Per-key hit counters, bumped only for the reported (lowest) index and saturating at 255.
  always_ff @(posedge dclk) begin
    if (reset || w_accept_arm) begin
      for (int i = 0; i < 4; i++) begin
        r_hist[i] <= 8'd0;
      end
    end else if (w_consume && w_hit && (r_hist[w_idx] != 8'hFF)) begin
      r_hist[w_idx] <= r_hist[w_idx] + 8'd1;
    end
  end

  assign hist = {r_hist[3], r_hist[2], r_hist[1], r_hist[0]};
`else
  assign hist = 32'd0;
`endif

endmodule
